// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard link.
//   - ps2_tx_state_e : host transmitter state encoding
//   - ERR_*          : err_code values reported by ps2_host_tx
//   - CMD_*, RESP_*  : common keyboard command / response bytes
//   - odd_parity()   : PS/2 parity bit for a data byte
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_SETUP,
    ST_REQ,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } ps2_tx_state_e;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_NO_RESP     = 2'b01;
  localparam logic [1:0] ERR_PKT_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_NO_ACK      = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS/2 pins into the CLOCK_50 domain.
// Ports:
//   CLOCK_50   in  system clock
//   reset      in  asynchronous, active-high
//   ps2_clk_in in  raw PS2_CLK pin level
//   ps2_dat_in in  raw PS2_DAT pin level
//   clk_sync   out PS2_CLK after a 2-flop synchroniser
//   dat_sync   out PS2_DAT after a 2-flop synchroniser
//   clk_fall   out one-cycle pulse when the filtered clock goes 1 -> 0
module ps2_line_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic       clk_meta_q, clk_meta_d;
  logic       clk_sync_q, clk_sync_d;
  logic       dat_meta_q, dat_meta_d;
  logic       dat_sync_q, dat_sync_d;
  logic [3:0] clk_hist_q, clk_hist_d;
  logic       clk_filt_q, clk_filt_d;
  logic       clk_fall_q, clk_fall_d;

  // The filtered clock only changes once four consecutive synced samples
  // agree, which rejects ringing on slow PS/2 edges.
  always_comb begin
    clk_meta_d = ps2_clk_in;
    clk_sync_d = clk_meta_q;
    dat_meta_d = ps2_dat_in;
    dat_sync_d = dat_meta_q;
    clk_hist_d = {clk_hist_q[2:0], clk_sync_q};
    clk_filt_d = clk_filt_q;
    if (&clk_hist_q) begin
      clk_filt_d = 1'b1;
    end else if (~|clk_hist_q) begin
      clk_filt_d = 1'b0;
    end
    clk_fall_d = clk_filt_q & ~clk_filt_d;
  end

  // Idle PS/2 lines are high, so everything resets high to avoid a
  // spurious fall when reset is released.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_hist_q <= 4'hF;
      clk_filt_q <= 1'b1;
      clk_fall_q <= 1'b0;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      clk_hist_q <= clk_hist_d;
      clk_filt_q <= clk_filt_d;
      clk_fall_q <= clk_fall_d;
    end
  end

  assign clk_sync = clk_sync_q;
  assign dat_sync = dat_sync_q;
  assign clk_fall = clk_fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (keyboard command path).
// Runs the request-to-send sequence: clock inhibit, start bit, 8 data bits
// LSB first, odd parity, stop, then waits for the device ACK.
// Ports:
//   CLOCK_50, reset        system clock, asynchronous active-high reset
//   tx_data, tx_start      command byte and single-cycle request (IDLE only)
//   tx_busy                high whenever not IDLE
//   tx_done, tx_err        one-cycle result pulses
//   err_code               01 no response, 10 packet timeout, 11 no ACK;
//                          held until the next accepted start
//   ps2_clk_in, ps2_dat_in raw pin levels
//   ps2_clk_oe, ps2_dat_oe open-drain enables (1 = pull line low)
//   rx_inhibit             tells the receive adapter to discard frames
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int RESP_TIMEOUT   = 750000,
  parameter int PKT_TIMEOUT    = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit
);

  // Down-counter reload values: a state loaded with N-1 lasts N cycles
  // when it leaves on terminal count.
  localparam logic [19:0] INHIBIT_LOAD = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] SETUP_LOAD   = 20'(SETUP_CYCLES - 1);
  localparam logic [19:0] RESP_LOAD    = 20'(RESP_TIMEOUT - 1);
  localparam logic [19:0] PKT_LOAD     = 20'(PKT_TIMEOUT - 1);

  ps2_tx_state_e state_q, state_d;
  logic [19:0]   cnt_q, cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    err_code_q, err_code_d;

  logic clk_sync;
  logic dat_sync;
  logic fall;

  ps2_line_sync u_line_sync (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .clk_fall   (fall)
  );

  // shift_q holds {stop, parity, d7..d0}; bit 0 is the bit on the wire.
  // bit_cnt_q counts device falls seen so far in DATA (1..9).
  // The packet window is loaded once on the first fall and keeps running
  // through ACK and WAIT_IDLE so it bounds the whole frame. A fall is
  // always checked before terminal count so it wins a tie.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != 20'd0) ? cnt_q - 20'd1 : cnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d    = ST_INHIBIT;
          cnt_d      = INHIBIT_LOAD;
          shift_d    = {1'b1, odd_parity(tx_data), tx_data};
          bit_cnt_d  = 4'd0;
          err_code_d = ERR_NONE;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == 20'd0) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 20'd0) begin
          state_d = ST_REQ;
          cnt_d   = RESP_LOAD;
        end
      end
      ST_REQ: begin
        if (fall) begin
          state_d   = ST_DATA;
          cnt_d     = PKT_LOAD;
          bit_cnt_d = 4'd1;
        end else if (cnt_q == 20'd0) begin
          state_d    = ST_ERR;
          err_code_d = ERR_NO_RESP;
        end
      end
      ST_DATA: begin
        if (fall) begin
          if (bit_cnt_q == 4'd9) begin
            state_d = ST_ACK;
          end else begin
            shift_d   = {1'b1, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (cnt_q == 20'd0) begin
          state_d    = ST_ERR;
          err_code_d = ERR_PKT_TIMEOUT;
        end
      end
      ST_ACK: begin
        if (fall) begin
          if (dat_sync) begin
            state_d    = ST_ERR;
            err_code_d = ERR_NO_ACK;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end else if (cnt_q == 20'd0) begin
          state_d    = ST_ERR;
          err_code_d = ERR_PKT_TIMEOUT;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_d = ST_DONE;
        end else if (cnt_q == 20'd0) begin
          state_d    = ST_ERR;
          err_code_d = ERR_PKT_TIMEOUT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 20'd0;
      shift_q    <= 10'h3FF;
      bit_cnt_q  <= 4'd0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  // Outputs decode straight from registered state, so reset releases the
  // lines without waiting for a clock edge.
  always_comb begin
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    case (state_q)
      ST_INHIBIT: ps2_clk_oe = 1'b1;
      ST_SETUP: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
      end
      ST_REQ:  ps2_dat_oe = 1'b1;
      ST_DATA: ps2_dat_oe = ~shift_q[0];
      default: begin
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
      end
    endcase
  end

  assign tx_busy    = (state_q != ST_IDLE);
  assign rx_inhibit = tx_busy;
  assign tx_done    = (state_q == ST_DONE);
  assign tx_err     = (state_q == ST_ERR);
  assign err_code   = err_code_q;

endmodule
